// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receive path with 16x oversampling and a 3-sample majority vote.
// Presents each recovered byte with a one-cycle data_valid or frame_err pulse.
module uart_receiver #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  // state | meaning
  // IDLE  | waiting for a falling edge on the synchronized line
  // START | qualifying the start bit, false start returns to IDLE
  // DATA  | sampling 8 data bits, LSB first
  // STOP  | checking the stop bit, leaves at mid-bit for resync
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int SAMPLE_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int CNT_W      = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

  state_t           r_state;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_rx_prev;
  logic [CNT_W-1:0] r_tick_cnt;
  logic [3:0]       r_s;
  logic [2:0]       r_bit_cnt;
  logic             r_samp7;
  logic             r_samp8;
  logic [7:0]       r_shift;
  logic [7:0]       r_data;
  logic             r_data_valid;
  logic             r_frame_err;
  logic             r_busy;

  logic w_rx_s;
  logic w_tick;
  logic w_start;
  logic w_maj;
  logic w_mid;
  logic w_end;

  assign w_rx_s  = r_sync2;
  assign w_tick  = (r_tick_cnt == CNT_LAST);
  assign w_start = !w_rx_s && r_rx_prev;
  // Third vote is the live s=9 sample, so the decision lands on the s=9 tick itself.
  assign w_maj   = (r_samp7 & r_samp8) | (r_samp7 & w_rx_s) | (r_samp8 & w_rx_s);
  assign w_mid   = w_tick && (r_s == 4'd9);
  assign w_end   = w_tick && (r_s == 4'd15);

  assign data       = r_data;
  assign data_valid = r_data_valid;
  assign frame_err  = r_frame_err;
  assign busy       = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_rx_prev    <= 1'b1;
      r_tick_cnt   <= '0;
      r_s          <= 4'd0;
      r_bit_cnt    <= 3'd0;
      r_samp7      <= 1'b0;
      r_samp8      <= 1'b0;
      r_shift      <= 8'h00;
      r_data       <= 8'h00;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_rx_prev    <= w_rx_s;
      r_tick_cnt   <= w_tick ? '0 : r_tick_cnt + CNT_W'(1);
      if (w_tick) begin
        r_s <= r_s + 4'd1;
        if (r_s == 4'd7) r_samp7 <= w_rx_s;
        if (r_s == 4'd8) r_samp8 <= w_rx_s;
      end
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state    <= START;
            r_tick_cnt <= '0;
            r_s        <= 4'd0;
            r_bit_cnt  <= 3'd0;
            r_busy     <= 1'b1;
          end
        end
        START: begin
          if (w_mid && w_maj) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_end) begin
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_mid) r_shift <= {w_maj, r_shift[7:1]};
          if (w_end) begin
            if (r_bit_cnt == 3'd7) r_state <= STOP;
            else                   r_bit_cnt <= r_bit_cnt + 3'd1;
          end
        end
        STOP: begin
          if (w_mid) begin
            r_data       <= r_shift;
            r_data_valid <= w_maj;
            r_frame_err  <= !w_maj;
            r_state      <= IDLE;
            r_busy       <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
UART RX stage. Consumes the serial line driven by the UART transmitter: 8N1, LSB first, idle high. Recovers each byte with 16x oversampling and a 3-sample majority vote. Presents the byte as a one-cycle valid pulse to the downstream logic. Sits directly downstream of the transmitter. On the bench it is driven by the transmitter with matching CLK_FREQ/BAUD_RATE.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD_RATE, 115200, line bit rate
OVERSAMPLE, 16, sample ticks per bit; fixed legal value 16
(derived) SAMPLE_DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer division; 54 at defaults

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
rx  input  1  asynchronous serial input, idle high
data  output  8  last received byte; held until next frame completes
data_valid  output  1  one-cycle pulse: data updated, stop bit good
frame_err  output  1  one-cycle pulse: stop bit sampled low
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (async assert, sync release):
  - data=0x00; data_valid=0; frame_err=0; busy=0; state=IDLE.
  - Synchronizer flops and the previous-rx register reset to 1.
  - All counters reset to 0.
- Input path: rx passes through 2 flops giving rx_s. rx_s is never combinationally sampled from rx.
- Tick generator:
  - Counter runs 0..SAMPLE_DIV-1 and emits tick when it reaches SAMPLE_DIV-1.
  - Counter is cleared to 0 on start detection.
  - Sample index s (4 bits) increments per tick. It wraps 15->0 at the end of each bit.
- Bit sampling: rx_s is captured at ticks s=7,8,9. The bit value is the majority of the 3 captures, so one corrupted sample is tolerated.
- FSM:
  - IDLE: busy=0. Start is detected on a falling edge only (rx_s==0 and previous rx_s==1). A line held low never re-triggers. On start: go to START, clear tick counter, s=0, bit_cnt=0.
  - START: at s=9, evaluate the majority.
    - If 1: false start, back to IDLE, no output pulse.
    - If 0: continue. At s=15 tick, go to DATA.
  - DATA: at s=9 of each bit, shift the majority bit into shift_reg from the MSB side (LSB first on the line). At s=15 tick, bit_cnt increments; after bit_cnt 7 completes, go to STOP.
  - STOP: at s=9, evaluate the majority.
    - If 1: data<=shift_reg, data_valid=1 for one cycle.
    - If 0: data<=shift_reg, frame_err=1 for one cycle, data_valid stays 0.
    - In both cases go to IDLE immediately at s=9 (half-bit early, so back-to-back frames resync).
- data_valid and frame_err are never high together. Each is high for exactly 1 clk per frame.
- No backpressure. A new frame overwrites data; the consumer must take data in the data_valid cycle or while data is held.
- Latency:
  - data_valid rises (9*16+10)*SAMPLE_DIV clocks (+2 sync, +/-1) after the rx falling edge.
  - At defaults this is 8316 +/-3 clocks.
- Reset mid-frame: aborts immediately to reset values. No pulse is emitted for the partial frame.
- Break (rx low > 1 frame): a single frame_err pulse. No further activity until rx returns high and falls again.
- Widths: tick counter is $clog2(SAMPLE_DIV) bits; s is 4 bits; bit_cnt is 3 bits.

Test Plan:
1. Reset with rx=1, hold 100 clk -> data=0x00, data_valid=0, frame_err=0, busy=0 throughout.
2. Transmitter sends 0x55 at defaults -> exactly one data_valid pulse, data=0x55, frame_err never high, busy low after the pulse.
3. Back-to-back bytes 0xA5, 0x3C, 0xFF, 0x00 with start re-asserted as soon as the transmitter's busy falls -> four data_valid pulses in order with matching data, no frame_err.
4. Glitch and noise, two parts:
   - rx low for 162 clk (3 ticks) then high -> busy rises then falls at START s=9, no data_valid or frame_err.
   - Send 0x00 with rx forced high for 54 clk around s=8 of data bit 3 -> data=0x00, data_valid=1.
5. Hand-driven frame 0x81 with stop bit low, rx held low 2 more bit times, then 0x42 sent -> frame_err pulse with data=0x81 and no data_valid, then a data_valid pulse with data=0x42.
6. rst_n asserted after data bit 4 of 0xC3, released 10 clk later, then 0x7E sent -> all outputs at reset values during reset, no pulse for 0xC3, then data_valid with data=0x7E.
